// File: rtl/ex_div_sequencer.sv
// ex_div_sequencer: EX-stage iterative divider for DIV/DIVU/REM/REMU.
// A request is captured in IDLE. RUN then performs 32 restoring
// shift-subtract steps, one per cycle, on the operand magnitudes. DONE
// presents the sign-corrected result for exactly one cycle.
// Optional feature: define DIV_EARLY_OUT_EN to let divide-by-zero, signed
// overflow and |dividend| < |divisor| jump from IDLE straight to DONE.
module ex_div_sequencer (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        DivReqE,
  input  logic [1:0]  DivOpE,
  input  logic [31:0] OperandAE,
  input  logic [31:0] OperandBE,
  input  logic        FlushE,
  output logic        StallE,
  output logic        DivBusyE,
  output logic        DivDoneE,
  output logic [31:0] DivResultE
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] quo_q, quo_d;     // dividend bits shift out, quotient bits shift in
  logic [31:0] rem_q, rem_d;     // partial remainder, always < divisor
  logic [31:0] dvsr_q, dvsr_d;   // divisor magnitude
  logic        is_rem_q, is_rem_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic        div_zero_q, div_zero_d;
  logic [31:0] res_q, res_d;

  // Operand decode at capture time: magnitudes and sign flags.
  logic        op_signed, a_neg, b_neg, accept;
  logic [31:0] abs_a, abs_b;

  assign op_signed = ~DivOpE[0];
  assign a_neg     = op_signed & OperandAE[31];
  assign b_neg     = op_signed & OperandBE[31];
  assign abs_a     = a_neg ? (~OperandAE + 32'd1) : OperandAE;
  assign abs_b     = b_neg ? (~OperandBE + 32'd1) : OperandBE;
  assign accept    = DivReqE & ~FlushE;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // When the subtraction fits, the difference is below the divisor and
  // therefore fits in 32 bits.
  logic [32:0] shifted;
  logic        step_ge;
  logic [31:0] step_rem, step_quo;

  assign shifted  = {rem_q, quo_q[31]};
  assign step_ge  = shifted >= {1'b0, dvsr_q};
  assign step_rem = step_ge ? (shifted[31:0] - dvsr_q) : shifted[31:0];
  assign step_quo = {quo_q[30:0], step_ge};

  // Apply signs and the divide-by-zero quotient. The remainder of a divide
  // by zero is |dividend| with the dividend's sign, i.e. the dividend itself.
  // Signed overflow falls out naturally: -(0x80000000) is 0x80000000, rem 0.
  function automatic logic [31:0] fix_result(
    input logic [31:0] quo,
    input logic [31:0] rem,
    input logic        is_rem,
    input logic        neg_quo,
    input logic        neg_rem,
    input logic        div_zero
  );
    logic [31:0] q, r;
    q = neg_quo ? (~quo + 32'd1) : quo;
    if (div_zero) q = 32'hFFFF_FFFF;
    r = neg_rem ? (~rem + 32'd1) : rem;
    return is_rem ? r : q;
  endfunction

  // Early-out detection: with the feature off these tie off to zero so the
  // long path always runs and produces identical results.
  logic        early;
  logic [31:0] early_res;
`ifdef DIV_EARLY_OUT_EN
  logic        ovf;
  logic [31:0] early_quo, early_rem;

  assign ovf       = op_signed & (OperandAE == 32'h8000_0000) & (OperandBE == 32'hFFFF_FFFF);
  assign early     = (OperandBE == 32'd0) | ovf | (abs_a < abs_b);
  assign early_quo = ovf ? 32'h8000_0000 : 32'd0;
  assign early_rem = ovf ? 32'd0 : abs_a;
  assign early_res = fix_result(early_quo, early_rem, DivOpE[1], a_neg ^ b_neg,
                                a_neg, OperandBE == 32'd0);
`else
  assign early     = 1'b0;
  assign early_res = 32'd0;
`endif

  // Next-state and datapath update.
  // NOTE: every _d gets its hold value first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    dvsr_d     = dvsr_q;
    is_rem_d   = is_rem_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    res_d      = res_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d      = 6'd0;
          quo_d      = abs_a;
          rem_d      = 32'd0;
          dvsr_d     = abs_b;
          is_rem_d   = DivOpE[1];
          neg_quo_d  = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          div_zero_d = (OperandBE == 32'd0);
          if (early) begin
            state_d = S_DONE;
            res_d   = early_res;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (!FlushE) begin
          cnt_d = cnt_q + 6'd1;
          quo_d = step_quo;
          rem_d = step_rem;
          if (cnt_q == 6'd31) begin
            state_d = S_DONE;
            res_d   = fix_result(step_quo, step_rem, is_rem_q, neg_quo_q,
                                 neg_rem_q, div_zero_q);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A flush kills whatever is in EX, including a request arriving this cycle.
    if (FlushE) state_d = S_IDLE;
  end

  // State and datapath registers.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q    <= S_IDLE;
      cnt_q      <= 6'd0;
      quo_q      <= 32'd0;
      rem_q      <= 32'd0;
      dvsr_q     <= 32'd0;
      is_rem_q   <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      res_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      dvsr_q     <= dvsr_d;
      is_rem_q   <= is_rem_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      res_q      <= res_d;
    end
  end

  // Outputs: stall drops in DONE so the pipeline advances with the result.
  assign StallE     = DivReqE & (state_q != S_DONE) & ~FlushE;
  assign DivBusyE   = (state_q == S_RUN);
  assign DivDoneE   = (state_q == S_DONE);
  assign DivResultE = res_q;

endmodule

// File: tb/tb_ex_div_sequencer.sv
// tb_ex_div_sequencer: scoreboard bench for ex_div_sequencer. Expected
// result and latency are pushed when a request is driven and popped when
// DivDoneE pulses. Inputs are driven on the falling edge and outputs are
// sampled on the falling edge.
module tb_ex_div_sequencer;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;
`ifdef DIV_EARLY_OUT_EN
  localparam bit EarlyEn = 1'b1;
`else
  localparam bit EarlyEn = 1'b0;
`endif

  typedef struct {
    logic [31:0] result;
    int          lat;
  } sb_item_t;

  logic        CLK, RESETn, DivReqE, FlushE;
  logic [1:0]  DivOpE;
  logic [31:0] OperandAE, OperandBE;
  logic        StallE, DivBusyE, DivDoneE;
  logic [31:0] DivResultE;

  sb_item_t    sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  int          done_cyc = 0;
  logic [31:0] last_res = 32'd0;

  ex_div_sequencer dut (
    .CLK       (CLK),
    .RESETn    (RESETn),
    .DivReqE   (DivReqE),
    .DivOpE    (DivOpE),
    .OperandAE (OperandAE),
    .OperandBE (OperandBE),
    .FlushE    (FlushE),
    .StallE    (StallE),
    .DivBusyE  (DivBusyE),
    .DivDoneE  (DivDoneE),
    .DivResultE(DivResultE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference result straight from the ISA definition.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [31:0] sa, sb, sr;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'd0 : 32'h8000_0000;
    if (!op[0]) begin
      sr = op[1] ? (sa % sb) : (sa / sb);
      return sr;
    end
    return op[1] ? (a % b) : (a / b);
  endfunction

  function automatic int model_lat(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    logic [31:0] ma, mb;
    bit          ovf, early;
    ma    = (!op[0] && a[31]) ? -a : a;
    mb    = (!op[0] && b[31]) ? -b : b;
    ovf   = !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    early = (b == 32'd0) || ovf || (ma < mb);
    return (EarlyEn && early) ? 1 : 33;
  endfunction

  // Drive one request and follow it to DivDoneE; returns at the DONE sample
  // with DivReqE still high, as the pipeline would hold it.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    sb_item_t item;
    int       lat, stall_cnt;
    item.result = model(op, a, b);
    item.lat    = model_lat(op, a, b);
    sb_q.push_back(item);
    @(negedge CLK);
    DivReqE = 1'b1; DivOpE = op; OperandAE = a; OperandBE = b;
    #1;
    stall_cnt = StallE ? 1 : 0;
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
      if (!DivDoneE) begin
        if (StallE) stall_cnt++;
        OperandAE = $urandom; OperandBE = $urandom; DivOpE = 2'($urandom_range(0, 3));
      end
    end while (!DivDoneE && lat < 100);
    item = sb_q.pop_front();
    if (!DivDoneE) begin
      check("done_timeout", 32'(lat), 32'(item.lat));
    end else begin
      check("result", DivResultE, item.result);
      check("latency", 32'(lat), 32'(item.lat));
      check("stall_cycles", 32'(stall_cnt), 32'(item.lat));
      check("stall_in_done", {31'd0, StallE}, 32'd0);
      last_res = item.result;
      done_cyc = cyc;
    end
  endtask

  // Pipeline moves on without a new divide; the result must hold.
  task automatic go_idle();
    @(negedge CLK);
    DivReqE = 1'b0;
    #1;
    check("done_after", {31'd0, DivDoneE}, 32'd0);
    check("result_hold", DivResultE, last_res);
  endtask

  task automatic expect_quiet(input string tag, input int n);
    int pulses;
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      if (DivDoneE) pulses++;
    end
    check(tag, 32'(pulses), 32'd0);
  endtask

  initial begin
    int d1;
    RESETn = 1'b0; DivReqE = 1'b1; FlushE = 1'b0;
    DivOpE = OP_DIV; OperandAE = 32'd0; OperandBE = 32'd0;
    #12;
    check("rst_stall", {31'd0, StallE}, 32'd1);
    check("rst_busy", {31'd0, DivBusyE}, 32'd0);
    check("rst_done", {31'd0, DivDoneE}, 32'd0);
    check("rst_result", DivResultE, 32'd0);
    DivReqE = 1'b0;
    @(negedge CLK);
    RESETn = 1'b1;

    // Directed cases.
    issue(OP_DIV, 32'd100, 32'd7);                       go_idle();
    issue(OP_REM, 32'hFFFF_FFF9, 32'd2);                 go_idle();
    issue(OP_DIVU, 32'd7, 32'd0);                        go_idle();
    issue(OP_REMU, 32'd7, 32'd0);                        go_idle();
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);         go_idle();
    issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);         go_idle();
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd0);                 go_idle();
    issue(OP_REM, 32'hFFFF_FFF9, 32'd0);                 go_idle();
    issue(OP_DIV, 32'hFFFF_FFFD, 32'd10);                go_idle();
    issue(OP_REM, 32'hFFFF_FFFD, 32'd10);                go_idle();
    issue(OP_DIV, 32'd1000, 32'hFFFF_FFFD);              go_idle();
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'd1);                go_idle();
    issue(OP_REMU, 32'hFFFF_FFFF, 32'h8000_0000);        go_idle();

    // Back-to-back: second request accepted from IDLE the cycle after DONE.
    issue(OP_DIVU, 32'd50, 32'd5);
    d1 = done_cyc;
    issue(OP_DIVU, 32'd9, 32'd3);
    check("b2b_gap", 32'(done_cyc - d1), 32'd34);
    go_idle();

    // Random mix.
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 50)) : $urandom;
      if (i[0]) b = -b;
      issue(2'($urandom_range(0, 3)), a, b);
      go_idle();
    end

    // Flush wins over a simultaneous request in IDLE.
    @(negedge CLK);
    DivReqE = 1'b1; FlushE = 1'b1; DivOpE = OP_DIVU; OperandAE = 32'd99; OperandBE = 32'd3;
    #1;
    check("flushwin_stall", {31'd0, StallE}, 32'd0);
    @(negedge CLK);
    DivReqE = 1'b0; FlushE = 1'b0;
    #1;
    check("flushwin_busy", {31'd0, DivBusyE}, 32'd0);
    expect_quiet("flushwin_no_done", 40);

    // Flush in RUN cycle 10.
    @(negedge CLK);
    DivReqE = 1'b1; DivOpE = OP_DIV; OperandAE = 32'd1000; OperandBE = 32'd3;
    for (int i = 0; i < 10; i++) @(negedge CLK);
    check("flush_busy_before", {31'd0, DivBusyE}, 32'd1);
    FlushE = 1'b1;
    #1;
    check("flush_stall", {31'd0, StallE}, 32'd0);
    @(negedge CLK);
    FlushE = 1'b0; DivReqE = 1'b0;
    #1;
    check("flush_busy_after", {31'd0, DivBusyE}, 32'd0);
    check("flush_stall_after", {31'd0, StallE}, 32'd0);
    check("flush_result_hold", DivResultE, last_res);
    expect_quiet("flush_no_done", 40);

    // Reset at RUN cycle 20.
    @(negedge CLK);
    DivReqE = 1'b1; DivOpE = OP_DIVU; OperandAE = 32'd12345; OperandBE = 32'd7;
    for (int i = 0; i < 20; i++) @(negedge CLK);
    check("midrst_busy_before", {31'd0, DivBusyE}, 32'd1);
    RESETn = 1'b0;
    #1;
    check("midrst_busy", {31'd0, DivBusyE}, 32'd0);
    check("midrst_done", {31'd0, DivDoneE}, 32'd0);
    check("midrst_result", DivResultE, 32'd0);
    check("midrst_stall", {31'd0, StallE}, 32'd1);
    DivReqE = 1'b0;
    @(negedge CLK);
    RESETn = 1'b1;
    expect_quiet("midrst_no_done", 40);
    check("midrst_busy_after", {31'd0, DivBusyE}, 32'd0);

    // Normal operation after reset.
    last_res = 32'd0;
    issue(OP_DIV, 32'd100, 32'd7);
    go_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
